clock_phase_gen: RTL and testbench
==================================

# clock_phase_gen

Generates the three clock-generator phase lines (CGPP, CGQP, CGRP) and their complements, plus the driver enable BOP, that feed the four-phase W/X/Y/Z clock drivers. It divides the single master clock into a repeating W→X→Y→Z phase sequence. It also provides warm-up after reset, a clean halt at the end of Z, and an optional single-cycle step for bench and maintenance use.

## Interface
Parameters:
- PHASE_CYCLES, 4: master-clock cycles per phase; ≥1.
- WARM_CYCLES, 8: master-clock cycles held in warm-up after reset; ≥1.

Ports:
- CLK  in  1  master clock; every register is clocked on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- HALT_REQ  in  1  level; request halt at the end of Z.
- STEP_REQ  in  1  rising edge requests one full W..Z cycle while halted.
- CGPP, CGPPN  out  1 each  P phase line and its complement.
- CGQP, CGQPN  out  1 each  Q phase line and its complement.
- CGRP, CGRPN  out  1 each  R phase line and its complement.
- BOP  out  1  driver enable.
- PHASE  out  2  current phase: 0=W, 1=X, 2=Y, 3=Z.
- HALTED  out  1  high while parked in the halted Z phase.
- STEP_ACK  out  1  one-cycle pulse when a step completes.

## Operation
- All outputs are registered. Every *N output is always the exact inverse of its true line.
- Phase levels (P, Q, R):
  - W = 1, Q held, 1
  - X = 0, 1, R held
  - Y = 1, Q held, 0
  - Z = 0, 0, R held
- In steady state this gives:
  - P toggles every phase.
  - R is high for W and X.
  - Q is high for X and Y.
- FSM states are WARMUP, RUN, HALT and STEP.
- WARMUP:
  - Entered on reset.
  - Outputs hold Z levels with BOP=0.
  - A counter runs WARM_CYCLES cycles, then the FSM goes to RUN with BOP=1 and PHASE=W.
- RUN:
  - The phase counter advances every PHASE_CYCLES cycles: W→X→Y→Z→W.
  - At the Z→W boundary, if HALT_REQ=1 the FSM goes to HALT instead; Z levels are held and HALTED=1.
  - Asserting HALT_REQ and then dropping it before that boundary has no effect.
- HALT:
  - BOP stays 1 and Z levels are held.
  - When HALT_REQ=0, the next edge enters RUN at W with HALTED=0.
  - A STEP_REQ rising edge with HALT_REQ=1 enters STEP at W.
- STEP:
  - Runs W, X, Y and Z for PHASE_CYCLES each, then returns to HALT.
  - STEP_ACK=1 on the return cycle only.
  - STEP_REQ edges during STEP are ignored.
  - HALT_REQ is not examined until the step completes.
- STEP_REQ edge detection uses a registered copy of STEP_REQ, which is cleared by reset.
- Reset values (asynchronous, applied immediately):
  - CGPP=CGQP=CGRP=0
  - CGPPN=CGQPN=CGRPN=1
  - BOP=0, PHASE=3, HALTED=0, STEP_ACK=0
  - All counters = 0, FSM = WARMUP
- Reset asserted mid-phase or mid-step abandons the sequence; warm-up restarts on release.
- Counter widths are $clog2 of the parameter, minimum 1 bit. Phase-counter wrap 3→0 is the only phase wrap.

## Timing
- BOP and the W levels appear on rising edge number WARM_CYCLES after RST_N deasserts. Edges are counted from the first edge with RST_N high, which is edge 1.
- Each phase lasts exactly PHASE_CYCLES cycles, so the full period is 4×PHASE_CYCLES. There are no gap cycles between phases.
- All phase-line and complement transitions occur on the same edge. There is no skew within the block.
- Halt takes effect on the edge that would have started W. Resume reaches W one edge after HALT_REQ is sampled low.
- Step: W starts one edge after the STEP_REQ rising edge is sampled. STEP_ACK rises 4×PHASE_CYCLES edges later, together with HALTED=1.

## Configuration
- CLOCK_PHASE_GEN_STEP_EN defined: the STEP state, the STEP_REQ edge detector and STEP_ACK are compiled in.
- Not defined:
  - STEP_REQ is ignored.
  - STEP_ACK is tied to 0.
  - HALT exits only when HALT_REQ=0.
  - The FSM has no STEP state.

## Test plan
Parameters for all scenarios: PHASE_CYCLES=4, WARM_CYCLES=8.
- Reset/warm-up: release RST_N → outputs hold reset values for 7 edges. On edge 8: BOP=1, CGPP=1, CGRP=1, CGQP=0, PHASE=0.
- Free run, 64 cycles:
  - Period is 16 cycles.
  - P pattern is 1,0,1,0 per phase.
  - R is high for phases 0–1; Q is high for phases 1–2.
  - Every *N output is the inverse of its true line on every cycle.
- Halt: assert HALT_REQ during X → Y and Z complete normally, then Z is held with HALTED=1 at the W boundary. Drop HALT_REQ → PHASE=0 and HALTED=0 one edge later.
- Step (macro on): halted, STEP_REQ pulse → exactly 16 cycles W..Z, then STEP_ACK is a single 1-cycle pulse and HALTED=1. A second STEP_REQ pulse during the step produces no extra cycle.
- Async reset during Y → all outputs reach reset values without waiting for a CLK edge. Warm-up of 8 cycles repeats.
- Macro off: halted, STEP_REQ pulses → outputs unchanged and STEP_ACK=0 throughout.

Source files
------------

// File: rtl/clock_phase_gen.sv
// -----------------------------------------------------------------------------
// clock_phase_gen
//
// Divides the master clock into a repeating W -> X -> Y -> Z phase sequence and
// drives the three phase lines (P, Q, R), their complements and the driver
// enable BOP for the four-phase W/X/Y/Z clock drivers. After reset the block
// sits in a warm-up period with Z levels and BOP low, then runs freely. A halt
// request parks the sequence in Z at the end of a full cycle. An optional
// single-step mode runs one complete W..Z cycle from the halted state.
//
// Optional feature macro: CLOCK_PHASE_GEN_STEP_EN
//   defined     : STEP state, STEP_REQ edge detector and STEP_ACK are built.
//   not defined : STEP_REQ is ignored, STEP_ACK is tied low, HALT leaves only
//                 when HALT_REQ drops.
//
// Parameters
//   PHASE_CYCLES : master-clock cycles per phase (>= 1)
//   WARM_CYCLES  : master-clock cycles spent in warm-up after reset (>= 1)
//
// Ports
//   CLK          in   master clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   HALT_REQ     in   level, request halt at the end of Z
//   STEP_REQ     in   rising edge requests one W..Z cycle while halted
//   CGPP/CGPPN   out  P phase line and complement
//   CGQP/CGQPN   out  Q phase line and complement
//   CGRP/CGRPN   out  R phase line and complement
//   BOP          out  driver enable
//   PHASE        out  current phase, 0=W 1=X 2=Y 3=Z
//   HALTED       out  high while parked in the halted Z phase
//   STEP_ACK     out  one-cycle pulse when a step completes
// -----------------------------------------------------------------------------
module clock_phase_gen #(
   parameter int PHASE_CYCLES = 4,
   parameter int WARM_CYCLES  = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       HALT_REQ,
   input  logic       STEP_REQ,
   output logic       CGPP,
   output logic       CGPPN,
   output logic       CGQP,
   output logic       CGQPN,
   output logic       CGRP,
   output logic       CGRPN,
   output logic       BOP,
   output logic [1:0] PHASE,
   output logic       HALTED,
   output logic       STEP_ACK
);

   localparam int PCW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int WCW = (WARM_CYCLES  > 1) ? $clog2(WARM_CYCLES)  : 1;
   localparam logic [PCW-1:0] PC_LAST = PCW'(PHASE_CYCLES - 1);
   localparam logic [WCW-1:0] WC_LAST = WCW'(WARM_CYCLES - 1);

`ifdef CLOCK_PHASE_GEN_STEP_EN
   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALT   = 2'd2,
      ST_STEP   = 2'd3
   } t_state;
`else
   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALT   = 2'd2
   } t_state;
`endif

   // Phase-line levels {P,Q,R} for a phase; "held" lines keep their value.
   function automatic logic [2:0] f_phase_levels(input logic [1:0] ph,
                                                 input logic [2:0] cur);
      case (ph)
         2'd0:    return {1'b1, cur[1], 1'b1};
         2'd1:    return {1'b0, 1'b1, cur[0]};
         2'd2:    return {1'b1, cur[1], 1'b0};
         default: return {2'b00, cur[0]};
      endcase
   endfunction

   t_state         r_state;
   logic [1:0]     r_phase;
   logic [PCW-1:0] r_pcnt;
   logic [WCW-1:0] r_wcnt;
   logic           r_p, r_q, r_r;
   logic           r_pn, r_qn, r_rn;
   logic           r_bop;
   logic           r_halted;

   t_state         w_nxt_state;
   logic [1:0]     w_nxt_phase;
   logic [PCW-1:0] w_nxt_pcnt;
   logic [WCW-1:0] w_nxt_wcnt;
   logic [2:0]     w_nxt_lv;
   logic           w_nxt_bop;
   logic           w_nxt_halted;
   logic           w_nxt_ack;

   logic [2:0]     w_lv;
   logic [1:0]     w_phase_inc;
   logic           w_phase_end;
   logic           w_step_rise;

   assign w_lv        = {r_p, r_q, r_r};
   assign w_phase_inc = r_phase + 2'd1;
   assign w_phase_end = (r_pcnt == PC_LAST);

`ifdef CLOCK_PHASE_GEN_STEP_EN
   logic r_step_d;
   logic r_ack;

   assign w_step_rise = STEP_REQ & ~r_step_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_step_d <= 1'b0;
         r_ack    <= 1'b0;
      end else begin
         r_step_d <= STEP_REQ;
         r_ack    <= w_nxt_ack;
      end
   end

   assign STEP_ACK = r_ack;
`else
   logic w_unused_step;

   assign w_step_rise   = 1'b0;
   assign w_unused_step = STEP_REQ ^ w_nxt_ack ^ w_step_rise;
   assign STEP_ACK      = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_WARMUP;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_phase  = r_phase;
      w_nxt_pcnt   = r_pcnt;
      w_nxt_wcnt   = r_wcnt;
      w_nxt_lv     = w_lv;
      w_nxt_bop    = r_bop;
      w_nxt_halted = r_halted;
      w_nxt_ack    = 1'b0;

      case (r_state)
         ST_WARMUP: begin
            w_nxt_bop = 1'b0;
            if (r_wcnt == WC_LAST) begin
               w_nxt_state = ST_RUN;
               w_nxt_wcnt  = '0;
               w_nxt_pcnt  = '0;
               w_nxt_phase = 2'd0;
               w_nxt_lv    = f_phase_levels(2'd0, w_lv);
               w_nxt_bop   = 1'b1;
            end else begin
               w_nxt_wcnt = r_wcnt + 1'b1;
            end
         end

         ST_RUN: begin
            if (w_phase_end) begin
               w_nxt_pcnt = '0;
               // HALT_REQ is only looked at on the Z -> W boundary, so a
               // request withdrawn earlier leaves no trace.
               if ((r_phase == 2'd3) && HALT_REQ) begin
                  w_nxt_state  = ST_HALT;
                  w_nxt_halted = 1'b1;
               end else begin
                  w_nxt_phase = w_phase_inc;
                  w_nxt_lv    = f_phase_levels(w_phase_inc, w_lv);
               end
            end else begin
               w_nxt_pcnt = r_pcnt + 1'b1;
            end
         end

         ST_HALT: begin
            if (!HALT_REQ) begin
               w_nxt_state  = ST_RUN;
               w_nxt_pcnt   = '0;
               w_nxt_phase  = 2'd0;
               w_nxt_lv     = f_phase_levels(2'd0, w_lv);
               w_nxt_halted = 1'b0;
            end
`ifdef CLOCK_PHASE_GEN_STEP_EN
            else if (w_step_rise) begin
               w_nxt_state  = ST_STEP;
               w_nxt_pcnt   = '0;
               w_nxt_phase  = 2'd0;
               w_nxt_lv     = f_phase_levels(2'd0, w_lv);
               w_nxt_halted = 1'b0;
            end
`endif
         end

`ifdef CLOCK_PHASE_GEN_STEP_EN
         ST_STEP: begin
            // Step edges and HALT_REQ are ignored until the cycle completes.
            if (w_phase_end) begin
               w_nxt_pcnt = '0;
               if (r_phase == 2'd3) begin
                  w_nxt_state  = ST_HALT;
                  w_nxt_halted = 1'b1;
                  w_nxt_ack    = 1'b1;
               end else begin
                  w_nxt_phase = w_phase_inc;
                  w_nxt_lv    = f_phase_levels(w_phase_inc, w_lv);
               end
            end else begin
               w_nxt_pcnt = r_pcnt + 1'b1;
            end
         end
`endif

         default: begin
            w_nxt_state = ST_WARMUP;
            w_nxt_wcnt  = '0;
            w_nxt_pcnt  = '0;
            w_nxt_bop   = 1'b0;
         end
      endcase
   end

   // Counters and registered outputs; complements are separate flops loaded
   // with the inverse so every line pair switches on the same edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_phase  <= 2'd3;
         r_pcnt   <= '0;
         r_wcnt   <= '0;
         r_p      <= 1'b0;
         r_q      <= 1'b0;
         r_r      <= 1'b0;
         r_pn     <= 1'b1;
         r_qn     <= 1'b1;
         r_rn     <= 1'b1;
         r_bop    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_phase  <= w_nxt_phase;
         r_pcnt   <= w_nxt_pcnt;
         r_wcnt   <= w_nxt_wcnt;
         r_p      <= w_nxt_lv[2];
         r_q      <= w_nxt_lv[1];
         r_r      <= w_nxt_lv[0];
         r_pn     <= ~w_nxt_lv[2];
         r_qn     <= ~w_nxt_lv[1];
         r_rn     <= ~w_nxt_lv[0];
         r_bop    <= w_nxt_bop;
         r_halted <= w_nxt_halted;
      end
   end

   assign CGPP   = r_p;
   assign CGPPN  = r_pn;
   assign CGQP   = r_q;
   assign CGQPN  = r_qn;
   assign CGRP   = r_r;
   assign CGRPN  = r_rn;
   assign BOP    = r_bop;
   assign PHASE  = r_phase;
   assign HALTED = r_halted;

endmodule

// File: tb/tb_clock_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_gen
//
// Directed bench for clock_phase_gen with PHASE_CYCLES=4, WARM_CYCLES=8.
// Output vector layout:
//   {CGPP,CGPPN,CGQP,CGQPN,CGRP,CGRPN,BOP,PHASE[1:0],HALTED,STEP_ACK}
// -----------------------------------------------------------------------------
module tb_clock_phase_gen;

   logic       CLK;
   logic       RST_N;
   logic       HALT_REQ;
   logic       STEP_REQ;
   logic       CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN;
   logic       BOP;
   logic [1:0] PHASE;
   logic       HALTED;
   logic       STEP_ACK;

   int checks = 0;
   int errors = 0;

   logic [10:0] obs;
   assign obs = {CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, BOP, PHASE, HALTED, STEP_ACK};

   clock_phase_gen #(
      .PHASE_CYCLES(4),
      .WARM_CYCLES (8)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .HALT_REQ(HALT_REQ),
      .STEP_REQ(STEP_REQ),
      .CGPP    (CGPP),
      .CGPPN   (CGPPN),
      .CGQP    (CGQP),
      .CGQPN   (CGQPN),
      .CGRP    (CGRP),
      .CGRPN   (CGRPN),
      .BOP     (BOP),
      .PHASE   (PHASE),
      .HALTED  (HALTED),
      .STEP_ACK(STEP_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [10:0] mk(input logic p, input logic q, input logic r,
                                      input logic bop, input logic [1:0] ph,
                                      input logic h, input logic a);
      return {p, ~p, q, ~q, r, ~r, bop, ph, h, a};
   endfunction

   // Expected outputs k cycles after the start of a W phase (steady state).
   function automatic logic [10:0] exp_run(input int k);
      logic [1:0] ph;
      ph = 2'((k / 4) % 4);
      case (ph)
         2'd0:    return mk(1'b1, 1'b0, 1'b1, 1'b1, ph, 1'b0, 1'b0);
         2'd1:    return mk(1'b0, 1'b1, 1'b1, 1'b1, ph, 1'b0, 1'b0);
         2'd2:    return mk(1'b1, 1'b1, 1'b0, 1'b1, ph, 1'b0, 1'b0);
         default: return mk(1'b0, 1'b0, 1'b0, 1'b1, ph, 1'b0, 1'b0);
      endcase
   endfunction

   logic [10:0] RST_VEC;
   logic [10:0] HALT_VEC;
   logic [10:0] ACK_VEC;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_N    = 1'b1;
      HALT_REQ = 1'b0;
      STEP_REQ = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (obs !== RST_VEC) begin
         errors++;
         $display("FAIL reset_async got %b want %b", obs, RST_VEC);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_held i=%0d got %b want %b", i, obs, RST_VEC);
         end
      end
      RST_N = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL warmup edge=%0d got %b want %b", e, obs, RST_VEC);
         end
      end
      tick();
      checks++;
      if (obs !== exp_run(0)) begin
         errors++;
         $display("FAIL warmup_end edge=8 got %b want %b", obs, exp_run(0));
      end
   endtask

   task automatic test_free_run();
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (obs !== exp_run(k)) begin
            errors++;
            $display("FAIL free_run k=%0d got %b want %b", k, obs, exp_run(k));
         end
         tick();
      end
   endtask

   task automatic test_halt_withdrawn();
      for (int k = 0; k <= 16; k++) begin
         checks++;
         if (obs !== exp_run(k)) begin
            errors++;
            $display("FAIL halt_withdrawn k=%0d got %b want %b", k, obs, exp_run(k));
         end
         HALT_REQ = (k >= 4 && k < 10);
         if (k < 16) tick();
      end
      HALT_REQ = 1'b0;
   endtask

   task automatic test_halt();
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (obs !== exp_run(k)) begin
            errors++;
            $display("FAIL halt_seq k=%0d got %b want %b", k, obs, exp_run(k));
         end
         if (k == 5) HALT_REQ = 1'b1;
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs !== HALT_VEC) begin
            errors++;
            $display("FAIL halt_park i=%0d got %b want %b", i, obs, HALT_VEC);
         end
         tick();
      end
      HALT_REQ = 1'b0;
      tick();
      checks++;
      if (obs !== exp_run(0)) begin
         errors++;
         $display("FAIL halt_resume got %b want %b", obs, exp_run(0));
      end
   endtask

`ifdef CLOCK_PHASE_GEN_STEP_EN
   task automatic test_step();
      logic [10:0] e;
      HALT_REQ = 1'b1;
      for (int k = 0; k < 16; k++) tick();
      checks++;
      if (obs !== HALT_VEC) begin
         errors++;
         $display("FAIL step_pre_halt got %b want %b", obs, HALT_VEC);
      end
      STEP_REQ = 1'b1;
      tick();
      STEP_REQ = 1'b0;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (obs !== exp_run(k)) begin
            errors++;
            $display("FAIL step_seq k=%0d got %b want %b", k, obs, exp_run(k));
         end
         if (k == 5) STEP_REQ = 1'b1;
         if (k == 7) STEP_REQ = 1'b0;
         tick();
      end
      checks++;
      if (obs !== ACK_VEC) begin
         errors++;
         $display("FAIL step_ack got %b want %b", obs, ACK_VEC);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         e = HALT_VEC;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL step_after i=%0d got %b want %b", i, obs, e);
         end
      end
   endtask
`else
   task automatic test_step_disabled();
      HALT_REQ = 1'b1;
      for (int k = 0; k < 16; k++) tick();
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (obs !== HALT_VEC) begin
            errors++;
            $display("FAIL step_disabled i=%0d got %b want %b", i, obs, HALT_VEC);
         end
         STEP_REQ = (i % 4 == 1);
         tick();
      end
      STEP_REQ = 1'b0;
   endtask
`endif

   task automatic test_async_reset();
      HALT_REQ = 1'b0;
      tick();
      for (int k = 0; k <= 9; k++) begin
         checks++;
         if (obs !== exp_run(k)) begin
            errors++;
            $display("FAIL pre_reset k=%0d got %b want %b", k, obs, exp_run(k));
         end
         if (k < 9) tick();
      end
      #3;
      RST_N = 1'b0;
      #1;
      checks++;
      if (obs !== RST_VEC) begin
         errors++;
         $display("FAIL async_reset_y got %b want %b", obs, RST_VEC);
      end
      tick();
      RST_N = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL rewarm edge=%0d got %b want %b", e, obs, RST_VEC);
         end
      end
      tick();
      checks++;
      if (obs !== exp_run(0)) begin
         errors++;
         $display("FAIL rewarm_end got %b want %b", obs, exp_run(0));
      end
   endtask

   initial begin
      RST_VEC  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
      HALT_VEC = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      ACK_VEC  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
      test_reset();
      test_free_run();
      test_halt_withdrawn();
      test_halt();
`ifdef CLOCK_PHASE_GEN_STEP_EN
      test_step();
`else
      test_step_disabled();
`endif
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
